// File: rtl/key_encoder83.sv
// -----------------------------------------------------------------------------
// key_encoder83
//
// Debounced 8-key priority encoder. Eight active-low push-buttons are
// synchronised, debounced on a slow sample tick, and priority-encoded into a
// registered 3-bit key code. The highest key index wins and maps to code
// 7 - index, so key[7] -> 3'b000 and key[0] -> 3'b111. With this mapping, the
// code lights the LED at the same bit position as the key when it drives the
// companion 3-8 LED decoder.
//
// Parameters
//   TICK_N     clocks per debounce sample tick (>= 2)
//   DEB_TICKS  consecutive mismatching ticks needed to accept a change (>= 1)
//   TICK_W     tick counter width, TICK_N <= 2**TICK_W
//   DEB_W      per-key debounce counter width, DEB_TICKS <= 2**DEB_W
//
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   key_n[7:0]     raw buttons, active-low, asynchronous to clk
//   key_code[2:0]  code of the highest-priority debounced key, held after
//                  release
//   key_valid      high while at least one debounced key is pressed
//   press_pulse    one-cycle strobe when key_code is loaded
//   release_pulse  one-cycle strobe when all keys become released
//
// Event outputs are plain one-cycle strobes. There is no back-pressure, so
// a consumer must sample every cycle in which a strobe is high.
// -----------------------------------------------------------------------------
module key_encoder83 #(
    parameter int TICK_N    = 12000,
    parameter int DEB_TICKS = 20,
    parameter int TICK_W    = 16,
    parameter int DEB_W     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] key_n,
    output logic [2:0] key_code,
    output logic       key_valid,
    output logic       press_pulse,
    output logic       release_pulse
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESSED = 1'b1
    } state_t;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_N - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_TICKS - 1);

    // -------------------------------------------------------------------------
    // Two-flop synchroniser. Resets to "released" so that nothing looks
    // pressed straight out of reset.
    // -------------------------------------------------------------------------
    logic [7:0] sync1;
    logic [7:0] sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 8'hFF;
            sync2 <= 8'hFF;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    // -------------------------------------------------------------------------
    // Sample tick: the counter runs 0..TICK_N-1 and wraps. The tick is high
    // in the cycle that holds the last count.
    // -------------------------------------------------------------------------
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Per-key debounce. cnt[i] counts ticks on which the synchronised level
    // differed from the accepted level deb[i]. Any cycle with a match clears
    // the count, so a bounce restarts qualification from zero. A glitch that
    // starts and ends between two ticks never reaches the counter.
    // -------------------------------------------------------------------------
    logic [7:0]       deb;
    logic [DEB_W-1:0] cnt [8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb <= 8'hFF;
            for (int i = 0; i < 8; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (tick) begin
                    if (cnt[i] == DEB_LAST) begin
                        deb[i] <= sync2[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Priority encode the debounced keys. The loop runs upward, so the
    // highest pressed index overwrites any lower one.
    // -------------------------------------------------------------------------
    logic [7:0] pressed;
    logic       any_pressed;
    logic [2:0] enc;

    assign pressed     = ~deb;
    assign any_pressed = |pressed;

    always_comb begin
        enc = 3'b000;
        for (int i = 0; i < 8; i++) begin
            if (pressed[i]) begin
                enc = 3'(7 - i);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Event FSM. Every output is registered here. The strobes default low
    // each cycle, so each one lasts exactly one clock. The FSM state is
    // visible externally as key_valid.
    // -------------------------------------------------------------------------
    state_t state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            key_code      <= 3'b000;
            key_valid     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_pressed) begin
                        state       <= PRESSED;
                        key_valid   <= 1'b1;
                        key_code    <= enc;
                        press_pulse <= 1'b1;
                    end
                end
                PRESSED: begin
                    if (!any_pressed) begin
                        // key_code is deliberately kept so that the last key
                        // stays readable after release.
                        state         <= IDLE;
                        key_valid     <= 1'b0;
                        release_pulse <= 1'b1;
                    end else if (enc != key_code) begin
                        // Either a higher key joined, or the winning key let
                        // go while a lower one is still held.
                        key_code    <= enc;
                        press_pulse <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    key_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_encoder83.sv
module tb_key_encoder83;

  localparam int TICK_N    = 4;
  localparam int DEB_TICKS = 3;

  logic       clk;
  logic       rst_n;
  logic [7:0] key_n;
  logic [2:0] key_code;
  logic       key_valid;
  logic       press_pulse;
  logic       release_pulse;

  int n_checks = 0;
  int n_errors = 0;
  int n_press  = 0;
  int n_rel    = 0;

  key_encoder83 #(
    .TICK_N(TICK_N),
    .DEB_TICKS(DEB_TICKS),
    .TICK_W(4),
    .DEB_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_n(key_n),
    .key_code(key_code),
    .key_valid(key_valid),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model. It works from the raw key history, a cycle index and
  // per-key counts of mismatching ticks. Each expected event is pushed as
  // {is_press, code}.
  // ---------------------------------------------------------------------------
  logic [3:0] exp_q[$];

  logic [7:0] hist[2];
  logic [7:0] m_deb;
  int         m_mis[8];
  int         m_cyc;
  logic       m_valid;
  logic [2:0] m_code;

  function automatic int top_code(input logic [7:0] accepted);
    for (int h = 7; h >= 0; h--) begin
      if (!accepted[h]) return 7 - h;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist[0] = 8'hFF;
      hist[1] = 8'hFF;
      m_deb   = 8'hFF;
      for (int i = 0; i < 8; i++) m_mis[i] = 0;
      m_cyc   = 0;
      m_valid = 1'b0;
      m_code  = 3'b000;
      exp_q.delete();
    end else begin
      int  c;
      bit  tk;
      logic [7:0] s;
      // Outputs react to the accepted levels as they stood before this edge.
      c = top_code(m_deb);
      if (!m_valid) begin
        if (c >= 0) begin
          m_valid = 1'b1;
          m_code  = 3'(c);
          exp_q.push_back({1'b1, 3'(c)});
        end
      end else if (c < 0) begin
        m_valid = 1'b0;
        exp_q.push_back({1'b0, m_code});
      end else if (3'(c) != m_code) begin
        m_code = 3'(c);
        exp_q.push_back({1'b1, 3'(c)});
      end
      // The synchronised view of the keys is the sample from two edges ago.
      s  = hist[1];
      tk = ((m_cyc % TICK_N) == TICK_N - 1);
      for (int i = 0; i < 8; i++) begin
        if (s[i] == m_deb[i]) begin
          m_mis[i] = 0;
        end else if (tk) begin
          m_mis[i] = m_mis[i] + 1;
          if (m_mis[i] == DEB_TICKS) begin
            m_deb[i] = s[i];
            m_mis[i] = 0;
          end
        end
      end
      hist[1] = hist[0];
      hist[0] = key_n;
      m_cyc   = m_cyc + 1;
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst_n) begin
      logic [3:0] got;
      logic [3:0] want;
      n_checks++;
      if (key_valid !== m_valid) begin
        n_errors++;
        $display("FAIL key_valid: got %b expected %b at %0t", key_valid, m_valid, $time);
      end
      n_checks++;
      if (key_code !== m_code) begin
        n_errors++;
        $display("FAIL key_code: got %b expected %b at %0t", key_code, m_code, $time);
      end
      n_checks++;
      if (press_pulse && release_pulse) begin
        n_errors++;
        $display("FAIL pulse_overlap: got press=1 release=1 expected at most one at %0t", $time);
      end
      if (press_pulse) n_press++;
      if (release_pulse) n_rel++;
      if (press_pulse || release_pulse) begin
        got = {press_pulse, key_code};
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_event: got %h expected none at %0t", got, $time);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            n_errors++;
            $display("FAIL event: got %h expected %h at %0t", got, want, $time);
          end
        end
      end else if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        n_checks++;
        n_errors++;
        $display("FAIL missed_event: got none expected %h at %0t", want, $time);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check_val(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_code"}, int'(key_code), 0);
    check_val({tag, "_valid"}, int'(key_valid), 0);
    check_val({tag, "_press"}, int'(press_pulse), 0);
    check_val({tag, "_release"}, int'(release_pulse), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int p0;
    int r0;
    logic [7:0] pat;
    rst_n = 1'b0;
    key_n = 8'h00;
    step(3);
    // 1. Reset with every key held.
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step(8);
    check_val("no_report_after_reset", int'(key_valid), 0);
    step(10);
    check_val("all_held_code", int'(key_code), 0);
    key_n = 8'hFF;
    step(25);
    check_val("all_released_valid", int'(key_valid), 0);

    // 2. Single press of key[2].
    p0 = n_press;
    r0 = n_rel;
    key_n = 8'b1111_1011;
    step(15);
    check_val("single_code", int'(key_code), 5);
    check_val("single_valid", int'(key_valid), 1);
    check_val("single_press_cnt", n_press - p0, 1);
    key_n = 8'hFF;
    step(20);
    check_val("single_rel_valid", int'(key_valid), 0);
    check_val("single_rel_cnt", n_rel - r0, 1);
    check_val("single_code_held", int'(key_code), 5);

    // 3. Bounce on key[5], then a steady hold.
    p0 = n_press;
    for (int i = 0; i < 10; i++) begin
      key_n = (i % 2 == 0) ? 8'b1101_1111 : 8'hFF;
      step(3);
    end
    check_val("bounce_no_press", n_press - p0, 0);
    check_val("bounce_no_valid", int'(key_valid), 0);
    key_n = 8'b1101_1111;
    step(20);
    check_val("bounce_code", int'(key_code), 2);
    check_val("bounce_press_cnt", n_press - p0, 1);
    key_n = 8'hFF;
    step(20);

    // 4. Priority changes while keys stay held.
    p0 = n_press;
    key_n = 8'b1111_1101;
    step(20);
    check_val("prio_k1_code", int'(key_code), 6);
    key_n = 8'b1011_1101;
    step(20);
    check_val("prio_k6_code", int'(key_code), 1);
    check_val("prio_k6_press_cnt", n_press - p0, 2);
    key_n = 8'b1111_1101;
    step(20);
    check_val("prio_back_code", int'(key_code), 6);
    check_val("prio_back_press_cnt", n_press - p0, 3);
    check_val("prio_back_valid", int'(key_valid), 1);
    key_n = 8'hFF;
    step(20);

    // 5. Several keys pressed together.
    p0 = n_press;
    key_n = 8'b0110_0111;
    step(20);
    check_val("simul_press_cnt", n_press - p0, 1);
    check_val("simul_code", int'(key_code), 0);
    key_n = 8'hFF;
    step(20);

    // 6. Reset while key[0] is reported.
    key_n = 8'b1111_1110;
    step(20);
    check_val("hold_k0_code", int'(key_code), 7);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    step(2);
    rst_n = 1'b1;
    step(8);
    check_val("midreset_requal_valid", int'(key_valid), 0);
    step(12);
    check_val("midreset_requal_code", int'(key_code), 7);
    check_val("midreset_requal_valid2", int'(key_valid), 1);
    key_n = 8'hFF;
    step(20);

    // Random patterns with varied hold times, including short bounces.
    for (int n = 0; n < 120; n++) begin
      case ($urandom_range(0, 3))
        0: pat = 8'hFF;
        1: pat = ~(8'h01 << $urandom_range(0, 7));
        2: pat = ~((8'h01 << $urandom_range(0, 7)) | (8'h01 << $urandom_range(0, 7)));
        default: pat = 8'($urandom_range(0, 255));
      endcase
      key_n = pat;
      step($urandom_range(1, 30));
    end
    key_n = 8'hFF;
    step(40);
    check_val("final_queue_empty", exp_q.size(), 0);
    check_val("final_valid", int'(key_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
